// File: rtl/neosd_dat_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : neosd_dat_fifo_if
// Description : Bus-side and SD DAT FSM-side handshake signals of the data
//               FIFO. The slave modport belongs to the FIFO; the master
//               modport belongs to whoever drives the bus and FSM sides.
// Revision    : 1.0 - initial release
// ============================================================================
interface neosd_dat_fifo_if #(
    parameter int DATA_W = 32
);
    // Wishbone register-file side
    logic              bus_wr_i;
    logic [DATA_W-1:0] bus_dat_i;
    logic              bus_rd_i;
    logic [DATA_W-1:0] bus_dat_o;

    // SD DAT FSM side, TX direction
    logic              fsm_tx_valid_o;
    logic [DATA_W-1:0] fsm_tx_dat_o;
    logic              fsm_tx_ready_i;

    // SD DAT FSM side, RX direction
    logic              fsm_rx_valid_i;
    logic [DATA_W-1:0] fsm_rx_dat_i;
    logic              fsm_rx_ready_o;

    modport slave (
        input  bus_wr_i, bus_dat_i, bus_rd_i, fsm_tx_ready_i,
               fsm_rx_valid_i, fsm_rx_dat_i,
        output bus_dat_o, fsm_tx_valid_o, fsm_tx_dat_o, fsm_rx_ready_o
    );

    modport master (
        output bus_wr_i, bus_dat_i, bus_rd_i, fsm_tx_ready_i,
               fsm_rx_valid_i, fsm_rx_dat_i,
        input  bus_dat_o, fsm_tx_valid_o, fsm_tx_dat_o, fsm_rx_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/neosd_dat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : neosd_dat_fifo
// Description : Direction-selectable DEPTH-entry data FIFO between the
//               Wishbone register file and the SD DAT FSM. TX: bus pushes,
//               FSM pops (first-word fall-through). RX: FSM pushes, bus pops
//               (registered, one-cycle latency). Provides fill level,
//               watermark interrupt and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module neosd_dat_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    input  wire logic          dir_i,
    input  wire logic          flush_i,
    input  wire logic          clr_err_i,
    input  wire logic [AW:0]   watermark_i,
    neosd_dat_fifo_if.slave    io,
    output logic      [AW:0]   level_o,
    output logic               empty_o,
    output logic               full_o,
    output logic               irq_o,
    output logic               ovf_o,
    output logic               udf_o
);

    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    // Storage (not reset) and state registers
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q,  level_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;
    logic              irq_q,    irq_d;
    logic [DATA_W-1:0] bus_dat_q, bus_dat_d;
    logic              dir_q;

    // Decoded per-cycle events
    logic              w_dir_ok;
    logic              w_active;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_evt;
    logic              w_udf_evt;
    logic [DATA_W-1:0] w_push_dat;

    // Handshake outputs and event decode. Outputs are also qualified by the
    // registered direction so that, in the cycle dir_i flips, the old
    // direction's contents are never offered and no handshake is accepted
    // that would then be thrown away by the implicit flush.
    always_comb begin
        w_dir_ok   = (dir_q == dir_i);
        w_active   = w_dir_ok && !flush_i;
        w_empty    = (level_q == '0);
        w_full     = (level_q == C_DEPTH);

        io.fsm_tx_valid_o = !w_empty && !dir_i && w_dir_ok;
        io.fsm_rx_ready_o = !w_full  &&  dir_i && w_dir_ok;
        io.fsm_tx_dat_o   = mem_q[rd_ptr_q];
        io.bus_dat_o      = bus_dat_q;

        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_ovf_evt  = 1'b0;
        w_udf_evt  = 1'b0;
        w_push_dat = io.bus_dat_i;
        if (w_active) begin
            if (dir_i) begin
                w_push     = io.fsm_rx_valid_i && io.fsm_rx_ready_o;
                w_pop      = io.bus_rd_i && !w_empty;
                w_udf_evt  = io.bus_rd_i && w_empty;
                w_push_dat = io.fsm_rx_dat_i;
            end else begin
                w_push    = io.bus_wr_i && !w_full;
                w_pop     = io.fsm_tx_valid_o && io.fsm_tx_ready_i;
                w_ovf_evt = io.bus_wr_i && w_full;
            end
        end
    end

    // Next-state: pointers, level, flags, read data and watermark interrupt
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        bus_dat_d = bus_dat_q;

        if (!w_active) begin
            // Explicit flush or implicit flush on a direction change;
            // bus_dat_o deliberately holds its last value.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + C_LVL_ONE;
                2'b01:   level_d = level_q - C_LVL_ONE;
                default: level_d = level_q;
            endcase

            // A new error event beats a simultaneous clear.
            if (w_ovf_evt) begin
                ovf_d = 1'b1;
            end else if (clr_err_i) begin
                ovf_d = 1'b0;
            end
            if (w_udf_evt) begin
                udf_d = 1'b1;
            end else if (clr_err_i) begin
                udf_d = 1'b0;
            end

            if (w_pop && dir_i) begin
                bus_dat_d = mem_q[rd_ptr_q];
            end else if (w_udf_evt) begin
                bus_dat_d = '0;
            end
        end

        // TX wants refill when space is available, RX when data is waiting.
        if (dir_i) begin
            irq_d = (level_d >= watermark_i) && (level_d != '0);
        end else begin
            irq_d = (level_d <= watermark_i);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            irq_q     <= 1'b0;
            bus_dat_q <= '0;
            dir_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            irq_q     <= irq_d;
            bus_dat_q <= bus_dat_d;
            dir_q     <= dir_i;
        end
    end

    // Storage write port; contents are left untouched by reset
    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) begin
            mem_q[wr_ptr_q] <= w_push_dat;
        end
    end

    assign level_o = level_q;
    assign empty_o = w_empty;
    assign full_o  = w_full;
    assign irq_o   = irq_q;
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;

endmodule
`default_nettype wire
